// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instruction_fetch_pkg;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HALT = 1'b1
  } fetch_state_e;

  localparam logic [31:0] HALT_INST_DEFAULT = 32'h0000_000C;
  localparam logic [31:0] NOP_INST          = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction memory request/response bus between the fetch stage and imem.
interface instruction_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;

  modport master (output imem_req, imem_addr, input imem_ready, imem_data);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_data);
endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with load enable and synchronous reset.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_b)    q <= RESET_PC;
    else if (load) q <= d;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: single-outstanding imem fetch with stall, redirect and halt.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
//
// state  | meaning
// S_REQ  | fetching sequentially; request issued whenever not locked
// S_HALT | halt instruction fetched; no requests until redirect or reset
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = HALT_INST_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_b,
  input  logic                lock,
  input  logic                redirect_valid,
  input  logic [31:0]         redirect_pc,
  instruction_fetch_if.master imem,
  output logic [31:0]         inst_if,
  output logic [31:0]         pc_if,
  output logic                fetch_valid,
  output logic                halted_controller_if
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall
`endif
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic         pc_load;
  logic [31:0]  inst_nxt, pc_if_nxt;
  logic         valid_nxt, halted_nxt;
  logic         handshake, fetch_done;
  logic         unused_rpc_lsb;

  assign unused_rpc_lsb = ^redirect_pc[1:0];

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk   (clk),
    .rst_b (rst_b),
    .load  (pc_load),
    .d     (pc_nxt),
    .q     (pc)
  );

  assign imem.imem_req  = rst_b && (state == S_REQ) && !lock;
  assign imem.imem_addr = pc;
  assign handshake      = imem.imem_req && imem.imem_ready;

  always_comb begin
    state_nxt  = state;
    pc_load    = 1'b0;
    pc_nxt     = pc;
    inst_nxt   = inst_if;
    pc_if_nxt  = pc_if;
    valid_nxt  = fetch_valid;
    halted_nxt = halted_controller_if;
    fetch_done = 1'b0;
    // A redirect wins over lock and discards any response arriving this cycle.
    if (redirect_valid) begin
      pc_load    = 1'b1;
      pc_nxt     = {redirect_pc[31:2], 2'b00};
      inst_nxt   = NOP_INST;
      valid_nxt  = 1'b0;
      halted_nxt = 1'b0;
      state_nxt  = S_REQ;
    end else if (!lock && (state == S_REQ)) begin
      if (handshake) begin
        fetch_done = 1'b1;
        inst_nxt   = imem.imem_data;
        pc_if_nxt  = pc;
        valid_nxt  = 1'b1;
        if (imem.imem_data == HALT_INST) begin
          halted_nxt = 1'b1;
          state_nxt  = S_HALT;
        end else begin
          pc_load = 1'b1;
          pc_nxt  = pc + PC_INC;
        end
      end else begin
        inst_nxt  = NOP_INST;
        valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) state <= S_REQ;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      inst_if              <= NOP_INST;
      pc_if                <= '0;
      fetch_valid          <= 1'b0;
      halted_controller_if <= 1'b0;
    end else begin
      inst_if              <= inst_nxt;
      pc_if                <= pc_if_nxt;
      fetch_valid          <= valid_nxt;
      halted_controller_if <= halted_nxt;
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (fetch_done)                perf_fetched <= perf_fetched + 32'd1;
      if (lock && (state == S_REQ))  perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  logic unused_fetch_done;
  assign unused_fetch_done = fetch_done;
`endif

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded at reset.
REQ-002 Parameter HALT_INST, default 32'h0000_000C (SYSCALL), encoding that halts fetch.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_b  in  1  synchronous active-low reset.
REQ-006 lock  in  1  stall from hazard unit; same signal drives the IF/ID buffer.
REQ-007 redirect_valid  in  1  branch/jump taken; overrides sequential PC.
REQ-008 redirect_pc  in  32  redirect target, word aligned.
REQ-009 imem_req  out  1  fetch request, combinational from state and lock.
REQ-010 imem_addr  out  32  fetch address, equal to current PC.
REQ-011 imem_ready  in  1  response valid; handshake completes when imem_req && imem_ready.
REQ-012 imem_data  in  32  instruction word, valid with imem_ready.
REQ-013 inst_if  out  32  registered instruction to IF/ID; 0 (NOP) when no valid fetch.
REQ-014 pc_if  out  32  registered PC of inst_if.
REQ-015 fetch_valid  out  1  registered; inst_if holds a real instruction.
REQ-016 halted_controller_if  out  1  registered; halt instruction fetched.

Function
REQ-017 FSM states SHALL be S_REQ and S_HALT.
REQ-018 imem_req SHALL be 1 only in S_REQ with lock=0; at most one request outstanding; imem_addr = PC.
REQ-019 Handshake in S_REQ without redirect SHALL load inst_if=imem_data, pc_if=PC, fetch_valid=1, PC<=PC+4 (mod 2^32) next cycle; fetch latency one cycle after handshake.
REQ-020 Handshake with imem_data==HALT_INST SHALL load it as in REQ-019, set halted_controller_if=1, go to S_HALT, hold PC.
REQ-021 Cycle with lock=0 and no handshake SHALL load inst_if=0, fetch_valid=0, and keep pc_if.
REQ-022 lock=1 SHALL hold PC, inst_if, pc_if, fetch_valid, halted_controller_if and the FSM state.
REQ-023 redirect_valid=1 SHALL set PC<=redirect_pc, flush inst_if=0, fetch_valid=0, discard any same-cycle response, regardless of lock.
REQ-024 redirect_valid=1 in S_HALT SHALL clear halted_controller_if and return to S_REQ (halt was speculative).
REQ-025 S_HALT SHALL issue no requests and hold outputs until redirect or reset.
REQ-026 redirect_pc[1:0] SHALL be ignored (forced 0).

Reset
REQ-027 rst_b=0 at a clock edge SHALL set PC=RESET_PC, state=S_REQ, inst_if=0, pc_if=0, fetch_valid=0, halted_controller_if=0, counters=0.
REQ-028 Reset mid-request SHALL drop the response; imem_req=0 while rst_b=0.

Configuration
REQ-029 Macro IF_PERF_CNT_EN defined: SHALL add outputs perf_fetched[31:0] (+1 per REQ-019/020 handshake) and perf_stall[31:0] (+1 per cycle lock=1 in S_REQ), both wrapping.
REQ-030 Macro undefined: those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-031 Package SHALL hold the fetch state enum, HALT_INST default, NOP constant and PC increment constant.
REQ-032 Sub-module pc_reg (32-bit PC, load-enable, sync reset to RESET_PC) SHALL be instantiated; other logic inline.

Verification
REQ-033 Reset release, imem_ready tied 1, data 0x2408_0001 -> imem_addr 0x0,0x4,0x8 in consecutive cycles; fetch_valid=1 each.
REQ-034 lock=1 for 3 cycles after fetch at 0x4 -> imem_req=0, inst_if/pc_if=0x4 held; fetch at 0x8 after release.
REQ-035 redirect_valid=1, redirect_pc=0x100 with same-cycle imem_ready -> data dropped, inst_if=0, next imem_addr=0x100.
REQ-036 imem_data=0x0000_000C at 0x10 -> halted_controller_if=1, imem_req=0 thereafter; redirect to 0x40 -> halt cleared, fetch at 0x40.
REQ-037 imem_ready low 4 cycles -> inst_if=0, fetch_valid=0, imem_addr stable; with IF_PERF_CNT_EN, perf_fetched counts only handshakes.
REQ-038 rst_b=0 mid-request at PC 0x20 -> all outputs reset; next imem_addr=RESET_PC.
